// File: rtl/ber_accum.sv
// ber_accum: bit-error accumulator that feeds the BER display stage.
//
// For each valid word it counts one received word and popcount(ERR_MASK) bit
// errors. Every INTERVAL cycles it copies the accumulators into RECV_CNT/ERR_CNT
// and pulses START for one cycle. If the display stage is BUSY, the snapshot
// waits until BUSY drops.
//
// Parameters
//   DW        word width. The display stage scales RECV_CNT by 16, so keep this at 16.
//   TMR_W     width of the update-interval timer
//   WINDOWED  0: counts are cumulative. 1: the accumulators restart at each snapshot.
//
// Ports
//   CLK, RSTX  clock and asynchronous active-low reset
//   EN         enables counting and the timer
//   CLR        synchronous clear of counts, timer and snapshot. Pulses START.
//   INTERVAL   snapshot period in cycles. A value of 0 behaves as 1.
//   DIN_VALID  ERR_MASK holds one received word this cycle
//   ERR_MASK   received XOR expected. Each set bit is one bit error.
//   BUSY       the display stage is busy
//   START      one-cycle pulse. RECV_CNT/ERR_CNT are valid from this cycle on.
//   RECV_CNT   snapshot of the received-word count
//   ERR_CNT    snapshot of the bit-error count
//   SAT        sticky. Set once an accumulator has reached all-ones.
module ber_accum #(
  parameter int unsigned DW       = 16,
  parameter int unsigned TMR_W    = 32,
  parameter bit          WINDOWED = 1'b0
) (
  input  logic             CLK,
  input  logic             RSTX,
  input  logic             EN,
  input  logic             CLR,
  input  logic [TMR_W-1:0] INTERVAL,
  input  logic             DIN_VALID,
  input  logic [DW-1:0]    ERR_MASK,
  input  logic             BUSY,
  output logic             START,
  output logic [59:0]      RECV_CNT,
  output logic [63:0]      ERR_CNT,
  output logic             SAT
);

  localparam int unsigned PcW = $clog2(DW + 1);
  localparam int unsigned RW  = 60;
  localparam int unsigned EW  = 64;

  typedef enum logic [1:0] {StIdle, StRun, StWait} state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d, ivl_m1;
  logic             v1_q, v1_d;
  logic [PcW-1:0]   pc1_q, pc, pc_add;
  logic [RW-1:0]    racc_q, racc_d, racc_inc, recv_q, recv_d;
  logic [EW-1:0]    eacc_q, eacc_d, eacc_inc, err_q, err_d;
  logic [RW:0]      racc_sum;
  logic [EW:0]      eacc_sum;
  logic             sat_q, sat_d, start_q, start_d;
  logic             expiry, snap;

  // Stage 1: popcount of the error mask.
  always_comb begin
    pc = '0;
    for (int i = 0; i < int'(DW); i++) begin
      pc = pc + PcW'(ERR_MASK[i]);
    end
  end

  assign v1_d = DIN_VALID & EN;

  // Interval timer. Use >= rather than == so that shrinking INTERVAL below the
  // current count expires right away instead of letting the timer wrap.
  assign ivl_m1 = (INTERVAL == '0) ? '0 : INTERVAL - TMR_W'(1);
  assign expiry = EN && (tmr_q >= ivl_m1);

  always_comb begin
    tmr_d = tmr_q;
    if (CLR) begin
      tmr_d = '0;
    end else if (EN) begin
      tmr_d = expiry ? '0 : tmr_q + TMR_W'(1);
    end
  end

  // Snapshot FSM. A START still high from the previous cycle is treated like
  // BUSY, so START is never high on two consecutive cycles.
  always_comb begin
    state_d = state_q;
    snap    = 1'b0;
    case (state_q)
      StIdle: begin
        if (EN) state_d = StRun;
      end
      StRun: begin
        if (!EN) begin
          state_d = StIdle;
        end else if (expiry) begin
          if (!BUSY && !start_q) snap = 1'b1;
          else                   state_d = StWait;
        end
      end
      StWait: begin
        if (!EN) begin
          state_d = StIdle;
        end else if (!BUSY && !start_q) begin
          snap    = 1'b1;
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
    if (CLR) begin
      state_d = EN ? StRun : StIdle;
      snap    = 1'b0;
    end
  end

  // Stage 2: saturating accumulators.
  assign pc_add   = v1_q ? pc1_q : '0;
  assign racc_sum = {1'b0, racc_q} + (RW + 1)'(v1_q);
  assign eacc_sum = {1'b0, eacc_q} + (EW + 1)'(pc_add);
  assign racc_inc = racc_sum[RW] ? '1 : racc_sum[RW-1:0];
  assign eacc_inc = eacc_sum[EW] ? '1 : eacc_sum[EW-1:0];

  always_comb begin
    racc_d = racc_inc;
    eacc_d = eacc_inc;
    // In windowed mode the snapshot takes the old totals, and this cycle's
    // contribution starts the next window, so no word is lost.
    if (WINDOWED && snap) begin
      racc_d = RW'(v1_q);
      eacc_d = EW'(pc_add);
    end
    if (CLR) begin
      racc_d = '0;
      eacc_d = '0;
    end
  end

  always_comb begin
    sat_d   = CLR ? 1'b0 : (sat_q | (&racc_d) | (&eacc_d));
    start_d = CLR | snap;
    recv_d  = recv_q;
    err_d   = err_q;
    if (CLR) begin
      recv_d = '0;
      err_d  = '0;
    end else if (snap) begin
      recv_d = racc_q;
      err_d  = eacc_q;
    end
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      v1_q    <= 1'b0;
      pc1_q   <= '0;
      racc_q  <= '0;
      eacc_q  <= '0;
      recv_q  <= '0;
      err_q   <= '0;
      sat_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      v1_q    <= CLR ? 1'b0 : v1_d;
      pc1_q   <= CLR ? '0 : pc;
      racc_q  <= racc_d;
      eacc_q  <= eacc_d;
      recv_q  <= recv_d;
      err_q   <= err_d;
      sat_q   <= sat_d;
      start_q <= start_d;
    end
  end

  assign START    = start_q;
  assign RECV_CNT = recv_q;
  assign ERR_CNT  = err_q;
  assign SAT      = sat_q;

endmodule

// File: tb/tb_ber_accum.sv
// Directed bench for ber_accum. A cumulative instance and a windowed instance
// share the same inputs. Inputs are driven and outputs sampled on the negedge.
// A "cycle" c is driven after edge c and sampled at edge c+1.
module tb_ber_accum;

  logic        clk = 1'b0;
  logic        rstx, en, clr, din_valid, busy;
  logic [31:0] interval;
  logic [15:0] err_mask;
  logic        start, sat, start_w, sat_w;
  logic [59:0] recv_cnt, recv_w;
  logic [63:0] err_cnt, err_w;

  always #5 clk = ~clk;

  ber_accum dut (
    .CLK(clk), .RSTX(rstx), .EN(en), .CLR(clr), .INTERVAL(interval),
    .DIN_VALID(din_valid), .ERR_MASK(err_mask), .BUSY(busy),
    .START(start), .RECV_CNT(recv_cnt), .ERR_CNT(err_cnt), .SAT(sat)
  );

  ber_accum #(.WINDOWED(1'b1)) dut_w (
    .CLK(clk), .RSTX(rstx), .EN(en), .CLR(clr), .INTERVAL(interval),
    .DIN_VALID(din_valid), .ERR_MASK(err_mask), .BUSY(busy),
    .START(start_w), .RECV_CNT(recv_w), .ERR_CNT(err_w), .SAT(sat_w)
  );

  int          n_chk = 0;
  int          n_bad = 0;
  int          first_cyc, last_cyc, n_start;
  logic [63:0] first_recv, first_err, last_recv, last_err;
  logic        b2b;
  int          exp_w [7] = '{2, 4, 4, 4, 4, 0, 0};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Run n cycles with DIN_VALID = vpat[i] and record the first and last START.
  task automatic run_cycles(input int n, input logic [31:0] vpat, input logic [15:0] mask);
    logic prev;
    prev      = 1'b0;
    first_cyc = -1;
    last_cyc  = -1;
    n_start   = 0;
    for (int i = 0; i < n; i++) begin
      din_valid = vpat[i];
      err_mask  = mask;
      step();
      if (start) begin
        n_start++;
        if (first_cyc < 0) begin
          first_cyc  = i + 1;
          first_recv = 64'(recv_cnt);
          first_err  = err_cnt;
        end
        last_cyc  = i + 1;
        last_recv = 64'(recv_cnt);
        last_err  = err_cnt;
        if (prev) b2b = 1'b1;
      end
      prev = start;
    end
    din_valid = 1'b0;
  endtask

  initial begin
    int k;
    int sum_r;
    rstx = 1'b0; en = 1'b0; clr = 1'b0; interval = 32'd8;
    din_valid = 1'b0; err_mask = '0; busy = 1'b0; b2b = 1'b0;
    step(); step();
    rstx = 1'b1;
    chk("rst_start", 64'(start), 64'd0);
    chk("rst_recv", 64'(recv_cnt), 64'd0);
    chk("rst_err", err_cnt, 64'd0);
    chk("rst_sat", 64'(sat), 64'd0);

    // 10 single-error words back to back, INTERVAL=8.
    en = 1'b1;
    run_cycles(18, 32'h3FF, 16'h0001);
    chk("t1_first_cyc", 64'(first_cyc), 64'd8);
    chk("t1_first_recv", first_recv, 64'd6);
    chk("t1_first_err", first_err, 64'd6);
    chk("t1_last_cyc", 64'(last_cyc), 64'd16);
    chk("t1_last_recv", last_recv, 64'd10);
    chk("t1_last_err", last_err, 64'd10);
    chk("t1_n_start", 64'(n_start), 64'd2);

    // Three all-error words with gaps between them.
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t2_clr_start", 64'(start), 64'd1);
    chk("t2_clr_recv", 64'(recv_cnt), 64'd0);
    run_cycles(10, 32'h15, 16'hFFFF);
    chk("t2_cyc", 64'(first_cyc), 64'd8);
    chk("t2_recv", first_recv, 64'd3);
    chk("t2_err", first_err, 64'd48);
    chk("t2_n_start", 64'(n_start), 64'd1);

    // BUSY held across two expiries, then released.
    interval = 32'd4;
    clr = 1'b1;
    step();
    clr = 1'b0;
    busy = 1'b1;
    run_cycles(8, 32'h1F, 16'h0003);
    chk("t3_busy_n", 64'(n_start), 64'd0);
    busy = 1'b0;
    run_cycles(3, 32'h0, 16'h0);
    chk("t3_cyc", 64'(first_cyc), 64'd1);
    chk("t3_recv", first_recv, 64'd5);
    chk("t3_err", first_err, 64'd10);
    chk("t3_n_start", 64'(n_start), 64'd1);

    // Saturation of the word accumulator.
    en = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t4_clr_start", 64'(start), 64'd1);
    chk("t4_clr_sat", 64'(sat), 64'd0);
    force dut.racc_q = 60'hFFF_FFFF_FFFF_FFFE;
    step();
    release dut.racc_q;
    en = 1'b1;
    interval = 32'd8;
    run_cycles(12, 32'h7, 16'h0);
    chk("t4_cyc", 64'(first_cyc), 64'd8);
    chk("t4_recv", first_recv, 64'h0FFF_FFFF_FFFF_FFFF);
    chk("t4_err", first_err, 64'd0);
    chk("t4_sat", 64'(sat), 64'd1);
    chk("t4_n_start", 64'(n_start), 64'd1);

    // CLR on an expiry edge with BUSY high.
    busy = 1'b1;
    run_cycles(3, 32'h0, 16'h0);
    chk("t6_pre_n", 64'(n_start), 64'd0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t6_start", 64'(start), 64'd1);
    chk("t6_recv", 64'(recv_cnt), 64'd0);
    chk("t6_err", err_cnt, 64'd0);
    chk("t6_sat", 64'(sat), 64'd0);
    busy = 1'b0;
    run_cycles(7, 32'h7, 16'h8000);
    chk("t6_no_pending", 64'(n_start), 64'd0);
    run_cycles(1, 32'h0, 16'h0);
    chk("t6_snap_cyc", 64'(first_cyc), 64'd1);
    chk("t6_snap_recv", first_recv, 64'd3);
    chk("t6_snap_err", first_err, 64'd3);

    // Go into WAIT, then apply an asynchronous reset mid-cycle.
    busy = 1'b1;
    run_cycles(9, 32'h0, 16'h0);
    chk("t6_wait_n", 64'(n_start), 64'd0);
    chk("t6_wait_hold", 64'(recv_cnt), 64'd3);
    #2 rstx = 1'b0;
    #1;
    chk("arst_start", 64'(start), 64'd0);
    chk("arst_recv", 64'(recv_cnt), 64'd0);
    chk("arst_err", err_cnt, 64'd0);
    chk("arst_sat", 64'(sat), 64'd0);
    chk("no_back2back", 64'(b2b), 64'd0);

    // Windowed instance: 18 words at one per cycle, INTERVAL=4.
    step();
    rstx = 1'b1;
    busy = 1'b0;
    interval = 32'd4;
    k = 0;
    sum_r = 0;
    for (int i = 0; i < 28; i++) begin
      din_valid = (i < 18);
      err_mask  = 16'h0101;
      step();
      if (start_w) begin
        if (k < 7) begin
          chk("win_recv", 64'(recv_w), 64'(exp_w[k]));
          chk("win_err", err_w, 64'(2 * exp_w[k]));
        end
        sum_r += int'(recv_w);
        k++;
      end
    end
    din_valid = 1'b0;
    chk("win_n_start", 64'(k), 64'd7);
    chk("win_total", 64'(sum_r), 64'd18);
    chk("win_sat", 64'(sat_w), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
